// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package router_pkg;

  localparam int PKT_LEN_W  = 6;
  localparam int PKT_DATA_W = PKT_LEN_W + 2;

  // Port 3 does not exist on the 1x3 router
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2,
    PAR  = 2'd3
  } tx_state_t;

  // Header byte layout: length in the upper bits, destination in the low two
  function automatic logic [PKT_DATA_W-1:0] hdr_pack(input logic [PKT_LEN_W-1:0] len,
                                                     input logic [1:0]           addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload byte store: 2**LEN_W x DATA_W registers, no reset on contents.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; the caller gates writes.
module router_pkt_buf #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**LEN_W];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port source: buffers a host payload, sends header/payload/parity.
// Latency: header is on data_out the cycle after start is accepted; N+2 beat cycles.
// Backpressure: busy high at an edge holds the current beat, state and parity.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ld_en,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [1:0]        dest_addr,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              corrupt,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_active,
  output logic              tx_done,
  output logic              start_err
);

  localparam logic [LEN_W-1:0] WR_MAX = {LEN_W{1'b1}};

  tx_state_t         state_q, state_d;
  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              corrupt_q, corrupt_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, active_d, done_d, err_d;

  logic              buf_we;
  logic [LEN_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] par_acc;
  logic              start_ok;
  logic              last_byte;

  router_pkt_buf #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign hdr       = DATA_W'(hdr_pack(PKT_LEN_W'(pkt_len), dest_addr));
  assign start_ok  = (dest_addr != ADDR_INVALID) && (pkt_len != '0) && (pkt_len <= wr_ptr_q);
  assign last_byte = (rd_ptr_q == len_q - LEN_W'(1));
  // data_out holds the payload byte being offered, so folding it in gives the running parity
  assign par_acc   = parity_q ^ data_out;
  // Look one byte ahead: the registered data_out must hold buf[rd_ptr_next]
  assign rd_addr   = (state_q == HDR) ? '0 : rd_ptr_q + LEN_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: advance on each accepted beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && start_ok)   state_d = HDR;
      HDR:  if (!busy)               state_d = PLD;
      PLD:  if (!busy && last_byte)  state_d = PAR;
      PAR:  if (!busy)               state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Next values for outputs, pointers and parity; everything holds while busy
  always_comb begin
    data_d    = data_out;
    valid_d   = pkt_valid;
    active_d  = tx_active;
    done_d    = 1'b0;
    err_d     = 1'b0;
    parity_d  = parity_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    corrupt_d = corrupt_q;
    buf_we    = 1'b0;
    case (state_q)
      IDLE: begin
        buf_we = ld_en && (wr_ptr_q != WR_MAX);
        if (buf_we) wr_ptr_d = wr_ptr_q + LEN_W'(1);
        if (start) begin
          if (start_ok) begin
            data_d    = hdr;
            valid_d   = 1'b1;
            active_d  = 1'b1;
            parity_d  = hdr;
            rd_ptr_d  = '0;
            len_d     = pkt_len;
            corrupt_d = corrupt;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (!busy) data_d = rd_data;
      end
      PLD: begin
        if (!busy) begin
          parity_d = par_acc;
          if (last_byte) begin
            valid_d = 1'b0;
            data_d  = par_acc ^ {{(DATA_W-1){1'b0}}, corrupt_q};
          end else begin
            rd_ptr_d = rd_ptr_q + LEN_W'(1);
            data_d   = rd_data;
          end
        end
      end
      PAR: begin
        if (!busy) begin
          data_d   = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      start_err <= 1'b0;
      parity_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      len_q     <= '0;
      corrupt_q <= 1'b0;
    end else begin
      pkt_valid <= valid_d;
      data_out  <= data_d;
      tx_active <= active_d;
      tx_done   <= done_d;
      start_err <= err_d;
      parity_q  <= parity_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      len_q     <= len_d;
      corrupt_q <= corrupt_d;
    end
  end

endmodule
